// File: rtl/game_pkg.sv
// Shared widths, move codes and arbiter FSM encoding for the player movement logic.
package game_pkg;
  localparam int POS_W  = 5;
  localparam int MOVE_W = 3;
  localparam int MAP_W  = 2;

  localparam logic [MOVE_W-1:0] MV_NONE  = 3'b000;
  localparam logic [MOVE_W-1:0] MV_UP    = 3'b001;
  localparam logic [MOVE_W-1:0] MV_DOWN  = 3'b010;
  localparam logic [MOVE_W-1:0] MV_LEFT  = 3'b011;
  localparam logic [MOVE_W-1:0] MV_RIGHT = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: grant=0 selects player 0, grant=1 selects player 1.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic grant
);
  logic last;

  // A tie goes to whoever was not granted last; a lone request always wins.
  always_comb begin
    grant = 1'b0;
    if (req0 && req1) grant = ~last;
    else if (req1)    grant = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                      last <= 1'b1;
    else if (take && (req0 || req1)) last <= grant;
  end
endmodule

// File: rtl/player_move_arbiter.sv
// Serialises player move requests through one shared collision detector and
// commits the result unless it would land on the other player.
module player_move_arbiter
  import game_pkg::*;
#(
  parameter int               CD_LATENCY = 0,
  parameter logic [POS_W-1:0] P0_X_INIT  = 5'd1,
  parameter logic [POS_W-1:0] P0_Y_INIT  = 5'd1,
  parameter logic [POS_W-1:0] P1_X_INIT  = 5'd30,
  parameter logic [POS_W-1:0] P1_Y_INIT  = 5'd30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p1_req,
  input  logic [MOVE_W-1:0] p0_move,
  input  logic [MOVE_W-1:0] p1_move,
  input  logic [MAP_W-1:0]  map,
  output logic [POS_W-1:0]  cd_x_pos,
  output logic [POS_W-1:0]  cd_y_pos,
  output logic [MOVE_W-1:0] cd_move,
  output logic [MAP_W-1:0]  cd_map,
  input  logic [POS_W-1:0]  cd_new_x_pos,
  input  logic [POS_W-1:0]  cd_new_y_pos,
  output logic [POS_W-1:0]  p0_x,
  output logic [POS_W-1:0]  p0_y,
  output logic [POS_W-1:0]  p1_x,
  output logic [POS_W-1:0]  p1_y,
  output logic              p0_ack,
  output logic              p1_ack,
  output logic              blocked,
  output logic              busy,
  output state_t            state
);
  localparam int CNT_W = 8;

  logic             arb_grant;
  logic             grant_q;
  logic             take;
  logic             hit;
  logic [CNT_W-1:0] wait_cnt;

  assign take = (state == ST_IDLE);
  assign busy = (state != ST_IDLE);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .reset (reset),
    .req0  (p0_req),
    .req1  (p1_req),
    .take  (take),
    .grant (arb_grant)
  );

  // The detector result is compared against the player that is not moving.
  assign hit = grant_q ? (cd_new_x_pos == p0_x && cd_new_y_pos == p0_y)
                       : (cd_new_x_pos == p1_x && cd_new_y_pos == p1_y);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      grant_q  <= 1'b0;
      wait_cnt <= '0;
      cd_x_pos <= P0_X_INIT;
      cd_y_pos <= P0_Y_INIT;
      cd_move  <= MV_NONE;
      cd_map   <= '0;
      p0_x     <= P0_X_INIT;
      p0_y     <= P0_Y_INIT;
      p1_x     <= P1_X_INIT;
      p1_y     <= P1_Y_INIT;
      p0_ack   <= 1'b0;
      p1_ack   <= 1'b0;
      blocked  <= 1'b0;
    end else begin
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (p0_req || p1_req) begin
            grant_q  <= arb_grant;
            cd_x_pos <= arb_grant ? p1_x : p0_x;
            cd_y_pos <= arb_grant ? p1_y : p0_y;
            cd_move  <= arb_grant ? p1_move : p0_move;
            cd_map   <= map;
            wait_cnt <= CNT_W'(CD_LATENCY);
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            blocked <= hit;
            if (!hit) begin
              if (grant_q) begin
                p1_x <= cd_new_x_pos;
                p1_y <= cd_new_y_pos;
              end else begin
                p0_x <= cd_new_x_pos;
                p0_y <= cd_new_y_pos;
              end
            end
            p0_ack <= ~grant_q;
            p1_ack <= grant_q;
            state  <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_player_move_arbiter.sv
// Directed bench: instance a (combinational detector, P1 starting beside P0) and
// instance b (3-cycle detector, default start positions).
module tb_player_move_arbiter;
  import game_pkg::*;

  localparam int B_LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- instance a ----------------
  logic a_reset, a_p0_req, a_p1_req;
  logic [2:0] a_p0_move, a_p1_move, a_cd_move;
  logic [1:0] a_map, a_cd_map;
  logic [4:0] a_cd_x, a_cd_y, a_new_x, a_new_y;
  logic [4:0] a_p0_x, a_p0_y, a_p1_x, a_p1_y;
  logic a_p0_ack, a_p1_ack, a_blocked, a_busy;
  state_t a_state;

  // ---------------- instance b ----------------
  logic b_reset, b_p0_req, b_p1_req;
  logic [2:0] b_p0_move, b_p1_move, b_cd_move;
  logic [1:0] b_map, b_cd_map;
  logic [4:0] b_cd_x, b_cd_y, b_new_x, b_new_y;
  logic [4:0] b_p0_x, b_p0_y, b_p1_x, b_p1_y;
  logic b_p0_ack, b_p1_ack, b_blocked, b_busy;
  state_t b_state;

  // Detector model: one step in the move direction, walls at 0 and 31.
  function automatic logic [9:0] cd_model(input logic [4:0] x, input logic [4:0] y,
                                          input logic [2:0] mv);
    logic [4:0] nx, ny;
    nx = x;
    ny = y;
    case (mv)
      MV_UP:    if (y != 5'd0)  ny = y - 5'd1;
      MV_DOWN:  if (y != 5'd31) ny = y + 5'd1;
      MV_LEFT:  if (x != 5'd0)  nx = x - 5'd1;
      MV_RIGHT: if (x != 5'd31) nx = x + 5'd1;
      default: ;
    endcase
    return {nx, ny};
  endfunction

  assign {a_new_x, a_new_y} = cd_model(a_cd_x, a_cd_y, a_cd_move);

  logic [9:0] b_pipe [B_LAT];
  always @(posedge clk) begin
    b_pipe[0] <= cd_model(b_cd_x, b_cd_y, b_cd_move);
    for (int i = 1; i < B_LAT; i++) b_pipe[i] <= b_pipe[i-1];
  end
  assign {b_new_x, b_new_y} = b_pipe[B_LAT-1];

  player_move_arbiter #(.CD_LATENCY(0), .P1_X_INIT(5'd2), .P1_Y_INIT(5'd1)) u_a (
    .clk(clk), .reset(a_reset), .p0_req(a_p0_req), .p1_req(a_p1_req),
    .p0_move(a_p0_move), .p1_move(a_p1_move), .map(a_map),
    .cd_x_pos(a_cd_x), .cd_y_pos(a_cd_y), .cd_move(a_cd_move), .cd_map(a_cd_map),
    .cd_new_x_pos(a_new_x), .cd_new_y_pos(a_new_y),
    .p0_x(a_p0_x), .p0_y(a_p0_y), .p1_x(a_p1_x), .p1_y(a_p1_y),
    .p0_ack(a_p0_ack), .p1_ack(a_p1_ack), .blocked(a_blocked), .busy(a_busy),
    .state(a_state)
  );

  player_move_arbiter #(.CD_LATENCY(B_LAT)) u_b (
    .clk(clk), .reset(b_reset), .p0_req(b_p0_req), .p1_req(b_p1_req),
    .p0_move(b_p0_move), .p1_move(b_p1_move), .map(b_map),
    .cd_x_pos(b_cd_x), .cd_y_pos(b_cd_y), .cd_move(b_cd_move), .cd_map(b_cd_map),
    .cd_new_x_pos(b_new_x), .cd_new_y_pos(b_new_y),
    .p0_x(b_p0_x), .p0_y(b_p0_y), .p1_x(b_p1_x), .p1_y(b_p1_y),
    .p0_ack(b_p0_ack), .p1_ack(b_p1_ack), .blocked(b_blocked), .busy(b_busy),
    .state(b_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-player move on instance a; player 1 selected by p.
  task automatic a_move(input string tag, input bit p, input logic [2:0] mv,
                        input logic [1:0] mp, input logic [4:0] ex, input logic [4:0] ey,
                        input logic eblk);
    if (p) begin a_p1_req = 1'b1; a_p1_move = mv; end
    else   begin a_p0_req = 1'b1; a_p0_move = mv; end
    a_map = mp;
    step();
    chk({tag, "_busy"}, a_busy, 1);
    chk({tag, "_cdmove"}, a_cd_move, mv);
    chk({tag, "_cdmap"}, a_cd_map, mp);
    chk({tag, "_ack_early"}, {a_p1_ack, a_p0_ack}, 2'b00);
    step();
    chk({tag, "_ack"}, {a_p1_ack, a_p0_ack}, p ? 2'b10 : 2'b01);
    chk({tag, "_blocked"}, a_blocked, eblk);
    chk({tag, "_pos"}, p ? {a_p1_x, a_p1_y} : {a_p0_x, a_p0_y}, {ex, ey});
    a_p0_req = 1'b0;
    a_p1_req = 1'b0;
    step();
    chk({tag, "_idle"}, {a_busy, a_p1_ack, a_p0_ack}, 3'b000);
  endtask

  initial begin
    a_reset = 1'b1; a_p0_req = 1'b0; a_p1_req = 1'b0;
    a_p0_move = MV_NONE; a_p1_move = MV_NONE; a_map = 2'd0;
    b_reset = 1'b1; b_p0_req = 1'b0; b_p1_req = 1'b0;
    b_p0_move = MV_NONE; b_p1_move = MV_NONE; b_map = 2'd0;
    repeat (4) step();

    // ---- instance a: reset values ----
    chk("a_rst_p0", {a_p0_x, a_p0_y}, {5'd1, 5'd1});
    chk("a_rst_p1", {a_p1_x, a_p1_y}, {5'd2, 5'd1});
    chk("a_rst_cd", {a_cd_x, a_cd_y, a_cd_move, a_cd_map}, {5'd1, 5'd1, 3'd0, 2'd0});
    chk("a_rst_flags", {a_busy, a_p0_ack, a_p1_ack, a_blocked}, 4'b0000);
    a_reset = 1'b0;
    step();
    chk("a_idle_after_rst", a_busy, 0);

    // p0 RIGHT onto p1 at (2,1): rejected, ack still pulses
    a_move("a_block", 1'b0, MV_RIGHT, 2'd2, 5'd1, 5'd1, 1'b1);
    chk("a_block_cdpos", {a_cd_x, a_cd_y}, {5'd1, 5'd1});
    a_move("a_p1_down", 1'b1, MV_DOWN, 2'd1, 5'd2, 5'd2, 1'b0);
    a_move("a_p0_right", 1'b0, MV_RIGHT, 2'd3, 5'd2, 5'd1, 1'b0);
    a_move("a_p0_left", 1'b0, MV_LEFT, 2'd0, 5'd1, 5'd1, 1'b0);
    a_move("a_p0_left2", 1'b0, MV_LEFT, 2'd0, 5'd0, 5'd1, 1'b0);
    a_move("a_p0_wall", 1'b0, MV_LEFT, 2'd0, 5'd0, 5'd1, 1'b0);

    // reset again so the round-robin pointer starts at player 1
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk("a_rst2_pos", {a_p0_x, a_p0_y, a_p1_x, a_p1_y}, {5'd1, 5'd1, 5'd2, 5'd1});
    step();

    // tie: p0 first
    a_p0_req = 1'b1; a_p0_move = MV_UP;
    a_p1_req = 1'b1; a_p1_move = MV_DOWN;
    step();
    chk("a_tie1_cd", {a_cd_x, a_cd_y, a_cd_move}, {5'd1, 5'd1, MV_UP});
    step();
    chk("a_tie1_ack", {a_p1_ack, a_p0_ack}, 2'b01);
    chk("a_tie1_pos", {a_p0_x, a_p0_y}, {5'd0 + 5'd1, 5'd0});
    a_p0_req = 1'b0;
    step();
    chk("a_tie1_idle", {a_busy, a_p0_ack}, 2'b00);
    // p0 raises again while p1 still waits: p1 wins this tie
    a_p0_req = 1'b1; a_p0_move = MV_NONE;
    step();
    chk("a_tie2_cd", {a_cd_x, a_cd_y, a_cd_move}, {5'd2, 5'd1, MV_DOWN});
    step();
    chk("a_tie2_ack", {a_p1_ack, a_p0_ack}, 2'b10);
    chk("a_tie2_pos", {a_p1_x, a_p1_y}, {5'd2, 5'd2});
    a_p1_req = 1'b0;
    step();
    step();
    chk("a_p0_next_cd", {a_cd_x, a_cd_y, a_cd_move}, {5'd1, 5'd0, MV_NONE});
    step();
    chk("a_none_ack", {a_p1_ack, a_p0_ack}, 2'b01);
    chk("a_none_pos", {a_p0_x, a_p0_y, a_blocked}, {5'd1, 5'd0, 1'b0});
    a_p0_req = 1'b0;
    step();
    chk("a_none_idle", a_busy, 0);

    // ---- instance b: 3-cycle detector ----
    chk("b_rst_pos", {b_p0_x, b_p0_y, b_p1_x, b_p1_y}, {5'd1, 5'd1, 5'd30, 5'd30});
    chk("b_rst_flags", {b_busy, b_p0_ack, b_p1_ack, b_blocked}, 4'b0000);
    b_reset = 1'b0;
    step();
    b_p0_req = 1'b1; b_p0_move = MV_RIGHT; b_map = 2'd1;
    step();
    chk("b_grant_cd", {b_cd_x, b_cd_y, b_cd_move, b_cd_map}, {5'd1, 5'd1, MV_RIGHT, 2'd1});
    b_p0_move = MV_LEFT; b_map = 2'd3;
    for (int i = 1; i <= B_LAT; i++) begin
      b_p1_req = (i == 1);
      step();
      chk("b_wait_cd", {b_cd_x, b_cd_y, b_cd_move, b_cd_map}, {5'd1, 5'd1, MV_RIGHT, 2'd1});
      chk("b_wait_ack", {b_busy, b_p1_ack, b_p0_ack}, 3'b100);
    end
    step();
    chk("b_ack", {b_p1_ack, b_p0_ack}, 2'b01);
    chk("b_pos", {b_p0_x, b_p0_y, b_blocked}, {5'd2, 5'd1, 1'b0});
    b_p0_req = 1'b0;
    step();
    chk("b_back_idle", {b_busy, b_p1_ack, b_p0_ack}, 3'b000);
    step();
    chk("b_p1_pulse_ignored", {b_busy, b_p1_ack}, 2'b00);

    // reset in the middle of WAIT aborts the move
    b_p1_req = 1'b1; b_p1_move = MV_LEFT;
    step();
    chk("b_abort_busy", b_busy, 1);
    step();
    b_reset = 1'b1;
    step();
    chk("b_abort_flags", {b_busy, b_p0_ack, b_p1_ack}, 3'b000);
    chk("b_abort_pos", {b_p0_x, b_p0_y, b_p1_x, b_p1_y}, {5'd1, 5'd1, 5'd30, 5'd30});
    b_reset = 1'b0;
    b_p1_req = 1'b0;
    repeat (B_LAT + 2) step();
    chk("b_abort_noack", {b_busy, b_p1_ack, b_p1_x, b_p1_y}, {1'b0, 1'b0, 5'd30, 5'd30});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/player_move_arbiter.md
PLAYER_MOVE_ARBITER -- requirements
Module: player_move_arbiter

Interface
REQ-001 Parameter CD_LATENCY, default 0: collision_detector result latency in clock cycles after its inputs change (0 = combinational).
REQ-002 Parameters P0_X_INIT 1, P0_Y_INIT 1, P1_X_INIT 30, P1_Y_INIT 30: reset positions, 5 bits each.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 p0_req, p1_req  in  1 each  level move request per player.
REQ-006 p0_move, p1_move  in  3 each  requested move, sampled at grant.
REQ-007 map  in  2  current map select, sampled at grant.
REQ-008 cd_x_pos, cd_y_pos  out  5 each  registered current position to collision_detector.
REQ-009 cd_move  out  3, cd_map  out  2  registered move and map to collision_detector.
REQ-010 cd_new_x_pos, cd_new_y_pos  in  5 each  detector result.
REQ-011 p0_x, p0_y, p1_x, p1_y  out  5 each  registered committed player positions.
REQ-012 p0_ack, p1_ack  out  1 each  one-cycle pulse: request completed.
REQ-013 blocked  out  1  valid with ack: move rejected by player-player collision.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Move codes: 000 NONE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT; 101-111 forwarded to detector unchanged; detector resolves walls, arbiter never clamps coordinates.
REQ-016 FSM states IDLE, WAIT, DONE; reset state IDLE.
REQ-017 IDLE: on edge with any req high, latch grant, load cd_* with granted player's position, move and map, load wait counter with CD_LATENCY, go WAIT.
REQ-018 Both req high in IDLE: grant player not granted last (round-robin); last-grant register resets to player 1 so player 0 wins first tie.
REQ-019 Single req: granted immediately regardless of round-robin pointer; pointer updates to granted player on every grant.
REQ-020 WAIT lasts CD_LATENCY+1 cycles; on its final edge sample cd_new_*; go DONE.
REQ-021 On that edge: if result equals other player's committed position (x and y both), keep old position, set blocked=1; else write result to granted player's position, blocked=0.
REQ-022 DONE: granted player's ack high exactly one cycle, blocked valid, new position already visible; next edge go IDLE.
REQ-023 Grant-to-ack latency: req sampled at edge E, ack high in cycle following edge E+CD_LATENCY+1.
REQ-024 Requester drops req at edge where ack sampled high; req still high in next IDLE cycle is a new request.
REQ-025 NONE move executes full sequence; position unchanged unless detector returns different value.
REQ-026 Requests, move and map changes while busy ignored; cd_* outputs stable from grant until return to IDLE.
REQ-027 Never both acks high; at most one outstanding transaction.

Reset
REQ-028 reset overrides all: state IDLE, positions to *_INIT, cd_x_pos/cd_y_pos to P0 init, cd_move 000, cd_map 00, acks 0, blocked 0, busy 0, wait counter 0, last grant 1.
REQ-029 Reset mid-WAIT or DONE aborts transaction: no ack, no position update.

Structure
REQ-030 Shared package game_pkg holds POS_W=5, MOVE_W=3, MAP_W=2, move code constants, FSM state encoding.
REQ-031 Sub-module rr_arbiter2 (two-request round-robin, grant and pointer update) instantiated once; rest in player_move_arbiter.

Verification
REQ-032 Bench models collision_detector with parameterized latency and wall at x=0/x=31.
REQ-033 CD_LATENCY=0, reset, p0_req with RIGHT -> p0 (1,1)->(2,1), p0_ack in 2nd cycle after request edge, blocked=0.
REQ-034 Both req same IDLE cycle -> p0 acked first, then p1; p0 held high again -> p1 wins next tie if p1 re-requests.
REQ-035 P1 at (2,1), p0 at (1,1) moves RIGHT -> p0 stays (1,1), blocked=1, p0_ack pulses.
REQ-036 CD_LATENCY=3 -> ack 5 cycles after grant edge; cd_* stable throughout; p1_req pulses during busy ignored.
REQ-037 Reset asserted in WAIT -> no ack, positions return to (1,1)/(30,30), busy 0 next cycle.
